qam16_slicer_demapper: RTL and testbench

//  Receive-side counterpart of the 16-QAM mapper/4x upsampler chain. It decimates the
//  4-samples-per-symbol I/Q stream at a selectable phase and slices each component to one
//  of four levels. It demaps the levels back to 4-bit symbols and counts symbol errors against
//  the delayed LFSR reference, reporting totals once per LFSR period. It sits after the

---
 rtl/qam16_slicer_demapper.sv | 157 +++++++++++++++
 tb/tb_qam16_slicer_demapper.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_slicer_demapper.sv
`default_nettype none
// ============================================================================
// Module   : qam16_slicer_demapper
// Purpose  : 16-QAM receive slicer and demapper. Decimates a 4-samples-per-
//            symbol I/Q stream at a selectable phase, slices each component
//            to one of four levels, demaps to a 4-bit symbol and counts
//            symbol errors against a delayed reference. Totals are reported
//            once per reference period.
// Ports    : clk           system clock (sys_clk domain)
//            reset_n       synchronous reset, active low
//            sam_clk_en    sample-rate enable pulse
//            sym_clk_en    symbol-rate enable pulse, precedes sample 0
//            sample_phase  which of the 4 samples per symbol is decided on
//            in_i, in_q    received samples, signed 1s17
//            threshold     outer decision threshold magnitude (2a), unsigned
//            ref_sym       transmitted reference symbol, valid on sym_clk_en
//            period_start  reference period marker, sampled on sym_clk_en
//            sym_out       demapped symbol {q_bits, i_bits}
//            sym_valid     1-clk pulse, sym_out updated
//            sym_count     symbols compared in the last complete period
//            err_count     symbol errors in the last complete period
//            result_valid  1-clk pulse, sym_count/err_count updated
// Revision : 1.0 - initial release
// ============================================================================
module qam16_slicer_demapper #(
    parameter int WIDTH     = 18,
    parameter int CNT_WIDTH = 22,
    parameter int REF_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sam_clk_en,
    input  logic                 sym_clk_en,
    input  logic [1:0]           sample_phase,
    input  logic [WIDTH-1:0]     in_i,
    input  logic [WIDTH-1:0]     in_q,
    input  logic [WIDTH-2:0]     threshold,
    input  logic [3:0]           ref_sym,
    input  logic                 period_start,
    output logic [3:0]           sym_out,
    output logic                 sym_valid,
    output logic [CNT_WIDTH-1:0] sym_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 result_valid
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_phase;
    logic [WIDTH-1:0]     r_cap_i;
    logic [WIDTH-1:0]     r_cap_q;
    logic                 r_cap_vld;
    logic [3:0]           r_ref_dly [REF_DELAY];
    logic [CNT_WIDTH-1:0] r_sym_acc;
    logic [CNT_WIDTH-1:0] r_err_acc;

    logic                 w_capture;
    logic                 w_close;
    logic [1:0]           w_i_bits;
    logic [1:0]           w_q_bits;
    logic [3:0]           w_ref;
    logic [CNT_WIDTH-1:0] w_sym_next;
    logic [CNT_WIDTH-1:0] w_err_next;

    // Four-level decision. Both operands are widened by one bit so that -T
    // and the most-negative input compare without overflow.
    function automatic logic [1:0] slice(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-2:0] t);
        logic signed [WIDTH:0] xe;
        logic signed [WIDTH:0] te;
        xe = {x[WIDTH-1], x};
        te = {2'b00, t};
        if (xe >= te)
            slice = 2'b10;
        else if (!xe[WIDTH])
            slice = 2'b11;
        else if (xe >= -te)
            slice = 2'b01;
        else
            slice = 2'b00;
    endfunction

    assign w_capture = sam_clk_en && (r_phase == sample_phase);
    assign w_close   = sym_clk_en && period_start;
    assign w_ref     = r_ref_dly[REF_DELAY-1];

    always_comb begin
        w_i_bits = slice(r_cap_i, threshold);
        w_q_bits = slice(r_cap_q, threshold);
    end

    // Accumulator next values include a compare landing in the current cycle,
    // so a close in that same cycle still reports it.
    always_comb begin
        w_sym_next = r_sym_acc;
        w_err_next = r_err_acc;
        if (sym_valid) begin
            if (!(&r_sym_acc))
                w_sym_next = r_sym_acc + C_CNT_ONE;
            if ((sym_out != w_ref) && !(&r_err_acc))
                w_err_next = r_err_acc + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase      <= 2'd0;
            r_cap_i      <= '0;
            r_cap_q      <= '0;
            r_cap_vld    <= 1'b0;
            sym_out      <= 4'd0;
            sym_valid    <= 1'b0;
            r_sym_acc    <= '0;
            r_err_acc    <= '0;
            sym_count    <= '0;
            err_count    <= '0;
            result_valid <= 1'b0;
            for (int k = 0; k < REF_DELAY; k++)
                r_ref_dly[k] <= 4'd0;
        end else begin
            // Symbol strobe realigns the sample counter ahead of sample 0.
            if (sym_clk_en)
                r_phase <= 2'd0;
            else if (sam_clk_en)
                r_phase <= r_phase + 2'd1;

            r_cap_vld <= w_capture;
            if (w_capture) begin
                r_cap_i <= in_i;
                r_cap_q <= in_q;
            end

            sym_valid <= r_cap_vld;
            if (r_cap_vld)
                sym_out <= {w_q_bits, w_i_bits};

            if (sym_clk_en) begin
                for (int k = REF_DELAY - 1; k > 0; k--)
                    r_ref_dly[k] <= r_ref_dly[k-1];
                r_ref_dly[0] <= ref_sym;
            end

            result_valid <= w_close;
            if (w_close) begin
                sym_count <= w_sym_next;
                err_count <= w_err_next;
                r_sym_acc <= '0;
                r_err_acc <= '0;
            end else begin
                r_sym_acc <= w_sym_next;
                r_err_acc <= w_err_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qam16_slicer_demapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam16_slicer_demapper
// Purpose  : Scoreboard bench for qam16_slicer_demapper. Expected symbols and
//            period totals are queued as stimulus is driven and popped when
//            the DUTs report. A second instance with 4-bit counters covers
//            accumulator saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam16_slicer_demapper;

    localparam int WIDTH     = 18;
    localparam int CNT_WIDTH = 22;
    localparam int SAT_CW    = 4;
    localparam int REF_DELAY = 4;
    localparam int NSYM      = 2402;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sam_clk_en = 1'b0;
    logic                 sym_clk_en = 1'b0;
    logic                 period_start = 1'b0;
    logic [1:0]           sample_phase = 2'd0;
    logic [WIDTH-1:0]     in_i = '0;
    logic [WIDTH-1:0]     in_q = '0;
    logic [WIDTH-2:0]     threshold = 17'd16384;
    logic [3:0]           ref_sym = 4'd0;

    logic [3:0]           sym_out;
    logic                 sym_valid;
    logic [CNT_WIDTH-1:0] sym_count;
    logic [CNT_WIDTH-1:0] err_count;
    logic                 result_valid;

    logic [3:0]           s_sym_out;
    logic                 s_sym_valid;
    logic [SAT_CW-1:0]    s_sym_count;
    logic [SAT_CW-1:0]    s_err_count;
    logic                 s_result_valid;

    qam16_slicer_demapper #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .REF_DELAY(REF_DELAY)) u_dut (
        .clk(clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .sample_phase(sample_phase), .in_i(in_i), .in_q(in_q), .threshold(threshold),
        .ref_sym(ref_sym), .period_start(period_start), .sym_out(sym_out),
        .sym_valid(sym_valid), .sym_count(sym_count), .err_count(err_count),
        .result_valid(result_valid)
    );

    qam16_slicer_demapper #(.WIDTH(WIDTH), .CNT_WIDTH(SAT_CW), .REF_DELAY(REF_DELAY)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .sample_phase(sample_phase), .in_i(in_i), .in_q(in_q), .threshold(threshold),
        .ref_sym(ref_sym), .period_start(period_start), .sym_out(s_sym_out),
        .sym_valid(s_sym_valid), .sym_count(s_sym_count), .err_count(s_err_count),
        .result_valid(s_result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct { logic [3:0] sym; int cyc; } sym_exp_t;
    typedef struct { longint n; longint e; } res_exp_t;

    sym_exp_t sym_q[$];
    res_exp_t res_q[$];
    res_exp_t res_sat_q[$];

    // ---------------------------------------------------------------- stimulus tables
    logic [WIDTH-1:0] s_i [NSYM][4];
    logic [WIDTH-1:0] s_q [NSYM][4];
    logic [3:0]       exp_sym  [NSYM];
    logic [3:0]       ref_want [NSYM + REF_DELAY];
    logic             ps_arr   [NSYM];
    logic [1:0]       ph_arr   [NSYM];

    // ---------------------------------------------------------------- reference model
    longint     acc_n = 0;
    longint     acc_e = 0;
    logic [3:0] dly_m [REF_DELAY];

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b10:   return 24576;
            2'b11:   return 8192;
            2'b01:   return -8192;
            default: return -24576;
        endcase
    endfunction

    function automatic logic [1:0] bits_of(input int v);
        case (v)
            24576:   return 2'b10;
            8192:    return 2'b11;
            -8192:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic longint clip(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    // Ideal-level symbol; wrong phases carry the negated level so a phase
    // slip would show up as a wrong decision.
    task automatic fill_ideal(input int k, input logic [1:0] ph, input logic flip_i);
        logic [3:0] tx;
        int li, lq;
        tx = 4'($urandom_range(0, 15));
        li = flip_i ? -lvl(tx[1:0]) : lvl(tx[1:0]);
        lq = lvl(tx[3:2]);
        for (int j = 0; j < 4; j++) begin
            s_i[k][j] = (j == int'(ph)) ? WIDTH'(li) : WIDTH'(-li);
            s_q[k][j] = (j == int'(ph)) ? WIDTH'(lq) : WIDTH'(-lq);
        end
        exp_sym[k] = {bits_of(lq), bits_of(li)};
        ph_arr[k]  = ph;
    endtask

    task automatic model_reset();
        acc_n = 0;
        acc_e = 0;
        for (int k = 0; k < REF_DELAY; k++) dly_m[k] = 4'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            next_cycle();
            sym_clk_en   = 1'b0;
            sam_clk_en   = 1'b0;
            period_start = 1'b0;
        end
    endtask

    task automatic send_symbol(input int k);
        next_cycle();
        sym_clk_en   = 1'b1;
        sam_clk_en   = 1'b0;
        period_start = ps_arr[k];
        ref_sym      = ref_want[k + REF_DELAY - 1];
        sample_phase = ph_arr[k];
        if (ps_arr[k]) begin
            res_q.push_back('{n: acc_n, e: acc_e});
            res_sat_q.push_back('{n: clip(acc_n, 15), e: clip(acc_e, 15)});
            acc_n = 0;
            acc_e = 0;
        end
        for (int d = REF_DELAY - 1; d > 0; d--) dly_m[d] = dly_m[d-1];
        dly_m[0] = ref_sym;
        acc_n++;
        if (exp_sym[k] != dly_m[REF_DELAY-1]) acc_e++;
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            sym_clk_en   = 1'b0;
            period_start = 1'b0;
            sam_clk_en   = 1'b1;
            in_i         = s_i[k][j];
            in_q         = s_q[k][j];
            if (j == int'(ph_arr[k]))
                sym_q.push_back('{sym: exp_sym[k], cyc: cyc + 2});
        end
    endtask

    // Reset with random inputs; outputs must read zero once the reset edge has
    // been sampled, including the first cycle after release.
    task automatic apply_reset(input int n);
        for (int c = 0; c < n; c++) begin
            next_cycle();
            reset_n      = 1'b0;
            sam_clk_en   = 1'($urandom_range(0, 1));
            sym_clk_en   = 1'($urandom_range(0, 1));
            period_start = 1'($urandom_range(0, 1));
            sample_phase = 2'($urandom_range(0, 3));
            in_i         = WIDTH'($urandom);
            in_q         = WIDTH'($urandom);
            ref_sym      = 4'($urandom_range(0, 15));
            if (c > 0) begin
                @(negedge clk);
                check_value("rst_sym_out", sym_out, 0);
                check_value("rst_sym_valid", sym_valid, 0);
                check_value("rst_sym_count", sym_count, 0);
                check_value("rst_err_count", err_count, 0);
                check_value("rst_result_valid", result_valid, 0);
                check_value("rst_sat_result_valid", s_result_valid, 0);
            end
        end
        next_cycle();
        reset_n      = 1'b1;
        sam_clk_en   = 1'b0;
        sym_clk_en   = 1'b0;
        period_start = 1'b0;
        in_i         = '0;
        in_q         = '0;
        @(negedge clk);
        check_value("rst_rel_sym_count", sym_count, 0);
        check_value("rst_rel_err_count", err_count, 0);
        check_value("rst_rel_result_valid", result_valid, 0);
        model_reset();
    endtask

    // ---------------------------------------------------------------- monitor
    logic [CNT_WIDTH-1:0] prev_n = '0;
    logic [CNT_WIDTH-1:0] prev_e = '0;

    always @(negedge clk) begin
        sym_exp_t se;
        res_exp_t re;
        if (reset_n) begin
            if (sym_valid) begin
                if (sym_q.size() == 0) check_value("sym_unexpected", 1, 0);
                else begin
                    se = sym_q.pop_front();
                    check_value("sym_out", sym_out, se.sym);
                    check_value("sym_latency", cyc, se.cyc);
                    check_value("sat_sym_out", s_sym_out, se.sym);
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) check_value("result_unexpected", 1, 0);
                else begin
                    re = res_q.pop_front();
                    check_value("sym_count", sym_count, re.n);
                    check_value("err_count", err_count, re.e);
                end
            end else begin
                if (sym_count != prev_n) check_value("sym_count_hold", sym_count, prev_n);
                if (err_count != prev_e) check_value("err_count_hold", err_count, prev_e);
            end
            if (s_result_valid) begin
                if (res_sat_q.size() == 0) check_value("sat_result_unexpected", 1, 0);
                else begin
                    re = res_sat_q.pop_front();
                    check_value("sat_sym_count", s_sym_count, re.n);
                    check_value("sat_err_count", s_err_count, re.e);
                end
            end
        end
        prev_n <= sym_count;
        prev_e <= err_count;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- sequence
    initial begin
        int edge_vals [7];
        logic [1:0] edge_bits [7];
        edge_vals = '{16384, 16383, 0, -1, -16384, -16385, -131072};
        edge_bits = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};

        for (int k = 0; k < NSYM + REF_DELAY; k++) ref_want[k] = 4'd0;
        for (int k = 0; k < NSYM; k++) ps_arr[k] = 1'b0;

        // Slicer edges at phase 0; Q at +a.
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 4; j++) begin
                s_i[k][j] = (j == 0) ? WIDTH'(edge_vals[k]) : WIDTH'(-131072);
                s_q[k][j] = (j == 0) ? WIDTH'(8192) : WIDTH'(-131072);
            end
            exp_sym[k] = {2'b11, edge_bits[k]};
            ph_arr[k]  = 2'd0;
        end
        // Phase select at phase 2: ramp 100..400, then distinct levels.
        for (int k = 7; k < 11; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (k < 9) begin
                    s_i[k][j] = WIDTH'(100 * (j + 1));
                    s_q[k][j] = '0;
                end else begin
                    s_i[k][j] = WIDTH'(lvl(2'(j == 0 ? 0 : j == 1 ? 1 : j == 2 ? 3 : 2)));
                    s_q[k][j] = WIDTH'(-lvl(2'(j == 0 ? 0 : j == 1 ? 1 : j == 2 ? 3 : 2)));
                end
            end
            exp_sym[k] = (k < 9) ? 4'b1111 : 4'b0111;
            ph_arr[k]  = 2'd2;
        end
        // Loopback period, then error-injection period at phase 2.
        for (int k = 11; k < 1011; k++) fill_ideal(k, 2'd0, 1'b0);
        for (int k = 1011; k < 2011; k++) fill_ideal(k, 2'd2, ((k - 1011) % 10) == 0);
        for (int k = 2011; k < 2361; k++) fill_ideal(k, 2'd1, 1'b0);
        for (int k = 2361; k < NSYM; k++) fill_ideal(k, 2'd0, 1'b0);
        for (int k = 0; k < NSYM; k++) begin
            if (k < 1011) ref_want[k] = exp_sym[k];
            else if (k < 2011) ref_want[k] = {s_q[k][ph_arr[k]] == WIDTH'(24576) ? 2'b10 : exp_sym[k][3:2],
                                              bits_of(((k - 1011) % 10) == 0 ? -int'($signed(s_i[k][ph_arr[k]]))
                                                                           : int'($signed(s_i[k][ph_arr[k]])))};
            else if (k < 2361) ref_want[k] = exp_sym[k];
            else ref_want[k] = ~exp_sym[k];
        end
        ps_arr[11]   = 1'b1;
        ps_arr[1011] = 1'b1;
        ps_arr[2011] = 1'b1;
        ps_arr[2361] = 1'b1;
        ps_arr[2381] = 1'b1;
        ps_arr[2401] = 1'b1;

        model_reset();
        apply_reset(3);
        for (int k = 0; k < 2311; k++) send_symbol(k);
        idle(6);
        check_value("pre_reset_sym_q", sym_q.size(), 0);
        check_value("pre_reset_res_q", res_q.size(), 0);
        apply_reset(3);
        for (int k = 2311; k < NSYM; k++) send_symbol(k);
        idle(8);
        check_value("end_sym_q", sym_q.size(), 0);
        check_value("end_res_q", res_q.size(), 0);
        check_value("end_res_sat_q", res_sat_q.size(), 0);
        // Error-injection period reference: every 10th of 1000 wrong.
        check_value("inject_model_total", ref_want[1011] != exp_sym[1011], 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
